// File: rtl/discrete_fixed_pkg.sv
// Shared fixed-point helpers for the discrete solver family: word type,
// saturation, saturating magnitude and the multiply-and-rescale primitive.
package discrete_fixed_pkg;

  localparam int FXP_PRECISION = 16;
  localparam int FXP_POINT     = 8;
  localparam int FXP_W         = FXP_PRECISION + FXP_POINT;

  // Default solver word; blocks with other widths size their own vectors.
  typedef logic signed [FXP_W-1:0] word_t;

  // FSM states of the residual checker.
  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROW
  } jr_state_e;

  // Helpers work on a 64-bit carrier so any word width up to 32 bits
  // (product up to 64 bits) can reuse them; callers cast back to their width.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v,
                                               input int w);
    logic signed [63:0] maxv;
    logic signed [63:0] minv;
    maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
    minv = -(64'sd1 <<< (w - 1));
    if (v > maxv)      return maxv;
    else if (v < minv) return minv;
    else               return v;
  endfunction

  // |v| clipped to the largest positive w-bit value, so the most negative
  // word maps to max rather than wrapping back to itself.
  function automatic logic signed [63:0] abs_sat(input logic signed [63:0] v,
                                                 input int w);
    logic signed [63:0] mag;
    mag = (v < 0) ? -v : v;
    return sat_w(mag, w);
  endfunction

  // Full product rescaled by an arithmetic shift, i.e. rounding toward -inf.
  function automatic logic signed [63:0] mul_shift(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int point);
    return (a * b) >>> point;
  endfunction

endpackage

// File: rtl/fxp_mul_shift.sv
// Fixed-point multiply with rescale: p = (a*b) >>> POINT truncated to W bits.
// Kept as its own combinational block so a pipelined version can drop in
// without touching the controlling FSM. Requires 2*W <= 64.
module fxp_mul_shift
  import discrete_fixed_pkg::*;
#(
  parameter int W     = 24,
  parameter int POINT = 8
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] p_o
);

  // Product is formed at full precision, then only the low W bits are kept.
  always_comb begin
    p_o = W'(mul_shift(64'(a_i), 64'(b_i), POINT));
  end

endmodule

// File: rtl/jacobi_residual.sv
// Residual checker: computes r = b - A*x row by row with one shared
// multiplier, tracks the max-abs norm and flags convergence against
// TOLERANCE once the last row is folded in.
module jacobi_residual
  import discrete_fixed_pkg::*;
#(
  parameter int SIZE      = 3,
  parameter int PRECISION = 16,
  parameter int POINT     = 8,
  parameter int TOLERANCE = 16
) (
  input  logic                                 clk,
  input  logic                                 I_RSTn,
  input  logic signed [PRECISION+POINT-1:0]    A [SIZE][SIZE],
  input  logic signed [PRECISION+POINT-1:0]    b [SIZE],
  input  logic signed [PRECISION+POINT-1:0]    x [SIZE],
  input  logic                                 start,
  output logic signed [PRECISION+POINT-1:0]    r [SIZE],
  output logic signed [PRECISION+POINT-1:0]    norm,
  output logic                                 converged,
  output logic                                 busy,
  output logic                                 ready
);

  localparam int W  = PRECISION + POINT;
  localparam int IW = $clog2(SIZE);
  localparam int AW = W + $clog2(SIZE) + 1;

  localparam logic [IW-1:0]       LAST  = IW'(SIZE - 1);
  localparam logic signed [W-1:0] TOL_W = W'(TOLERANCE);

  jr_state_e            state_q, state_d;
  logic [IW-1:0]        i_q, i_d;
  logic [IW-1:0]        j_q, j_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [W-1:0]  r_q [SIZE];
  logic signed [W-1:0]  r_d [SIZE];
  logic signed [W-1:0]  norm_q, norm_d;
  logic                 conv_q, conv_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;

  logic signed [W-1:0]  prod;
  logic signed [AW:0]   diff;
  logic signed [W-1:0]  rowRes;
  logic signed [W-1:0]  rowAbs;
  logic signed [W-1:0]  normMax;

  fxp_mul_shift #(
    .W     (W),
    .POINT (POINT)
  ) u_mul (
    .a_i (A[i_q][j_q]),
    .b_i (x[j_q]),
    .p_o (prod)
  );

  // Row result: subtract one bit wider than the accumulator so it cannot
  // wrap, then clip to the word range; the norm candidate is its magnitude.
  assign diff    = (AW+1)'(b[i_q]) - (AW+1)'(acc_q);
  assign rowRes  = W'(sat_w(64'(diff), W));
  assign rowAbs  = W'(abs_sat(64'(rowRes), W));
  assign normMax = (rowAbs > norm_q) ? rowAbs : norm_q;

  // State register and all result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      norm_q  <= '0;
      conv_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      for (int k = 0; k < SIZE; k++) r_q[k] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      norm_q  <= norm_d;
      conv_q  <= conv_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      r_q     <= r_d;
    end
  end

  // Sequencing: one MAC per cycle across a row, then one ROW cycle to
  // publish that row's residual and fold it into the norm.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    norm_d  = norm_q;
    conv_d  = conv_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    r_d     = r_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MAC;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
          norm_d  = '0;
          conv_d  = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      MAC: begin
        acc_d = acc_q + AW'(prod);
        if (j_q == LAST) begin
          j_d     = '0;
          state_d = ROW;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ROW: begin
        r_d[i_q] = rowRes;
        norm_d   = normMax;
        acc_d    = '0;
        if (i_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          conv_d  = (normMax <= TOL_W);
        end else begin
          i_d     = i_q + 1'b1;
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign r         = r_q;
  assign norm      = norm_q;
  assign converged = conv_q;
  assign busy      = busy_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_jacobi_residual.sv
// Directed bench for jacobi_residual at SIZE=3, Q16.8, TOLERANCE=16.
module tb_jacobi_residual;

  localparam int SIZE = 3;
  localparam int W    = 24;

  logic                clk    = 1'b0;
  logic                I_RSTn = 1'b0;
  logic                start  = 1'b0;
  logic signed [W-1:0] A [SIZE][SIZE];
  logic signed [W-1:0] b [SIZE];
  logic signed [W-1:0] x [SIZE];
  logic signed [W-1:0] r [SIZE];
  logic signed [W-1:0] norm;
  logic                converged;
  logic                busy;
  logic                ready;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  jacobi_residual #(
    .SIZE      (SIZE),
    .PRECISION (16),
    .POINT     (8),
    .TOLERANCE (16)
  ) dut (
    .clk       (clk),
    .I_RSTn    (I_RSTn),
    .A         (A),
    .b         (b),
    .x         (x),
    .start     (start),
    .r         (r),
    .norm      (norm),
    .converged (converged),
    .busy      (busy),
    .ready     (ready)
  );

  // Matrix setup: zero everywhere, scale s on the diagonal.
  task automatic setDiag(input int s);
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        A[i][j] = (i == j) ? W'(s) : '0;
  endtask

  task automatic setAll(input int s);
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        A[i][j] = W'(s);
  endtask

  task automatic setVec(input int x0, input int x1, input int x2,
                        input int b0, input int b1, input int b2);
    x[0] = W'(x0); x[1] = W'(x1); x[2] = W'(x2);
    b[0] = W'(b0); b[1] = W'(b1); b[2] = W'(b2);
  endtask

  // Pulse start for one edge and count edges until ready (bounded).
  task automatic runEval(output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 0;
    while (ready !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    #12;
    testsRun++;
    if (busy !== 1'b0 || ready !== 1'b0 || converged !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got busy=%b ready=%b conv=%b, expected 0 0 0",
               busy, ready, converged);
    end
    testsRun++;
    if (norm !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_norm: got %0d, expected 0", norm);
    end
    for (int k = 0; k < SIZE; k++) begin
      testsRun++;
      if (r[k] !== '0) begin
        testsFailed++;
        $display("[TB] FAIL reset_r[%0d]: got %0d, expected 0", k, r[k]);
      end
    end
    @(negedge clk);
    I_RSTn = 1'b1;
  endtask

  task automatic test_identity();
    int cyc;
    int er[SIZE];
    setDiag(256);
    setVec(256, 512, -256, 256, 512, -256);
    er = '{0, 0, 0};
    runEval(cyc);
    testsRun++;
    if (cyc !== 12) begin
      testsFailed++;
      $display("[TB] FAIL identity_latency: got %0d, expected 12", cyc);
    end
    for (int k = 0; k < SIZE; k++) begin
      testsRun++;
      if (r[k] !== W'(er[k])) begin
        testsFailed++;
        $display("[TB] FAIL identity_r[%0d]: got %0d, expected %0d", k, r[k], er[k]);
      end
    end
    testsRun++;
    if (norm !== '0 || converged !== 1'b1 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL identity_norm: got norm=%0d conv=%b busy=%b, expected 0 1 0",
               norm, converged, busy);
    end
  endtask

  task automatic test_offset();
    int cyc;
    setDiag(512);
    setVec(256, 256, 256, 768, 768, 768);
    runEval(cyc);
    for (int k = 0; k < SIZE; k++) begin
      testsRun++;
      if (r[k] !== W'(256)) begin
        testsFailed++;
        $display("[TB] FAIL offset_r[%0d]: got %0d, expected 256", k, r[k]);
      end
    end
    testsRun++;
    if (norm !== W'(256) || converged !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL offset_norm: got norm=%0d conv=%b, expected 256 0", norm, converged);
    end
  endtask

  // Row 0 mixes a negative coefficient and a negative x; rows 1-2 are 1.0*I.
  task automatic test_sign_shift();
    int cyc;
    int er[SIZE];
    setDiag(256);
    A[0][0] = -W'(384);
    A[0][1] = W'(128);
    setVec(256, -512, 0, 0, 0, 0);
    er = '{640, 512, 0};
    runEval(cyc);
    for (int k = 0; k < SIZE; k++) begin
      testsRun++;
      if (r[k] !== W'(er[k])) begin
        testsFailed++;
        $display("[TB] FAIL sign_r[%0d]: got %0d, expected %0d", k, r[k], er[k]);
      end
    end
    testsRun++;
    if (norm !== W'(640) || converged !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL sign_norm: got norm=%0d conv=%b, expected 640 0", norm, converged);
    end
  endtask

  // (-1 * 1) >>> 8 must give -1, so r[0] = 0 - (-1) = 1.
  task automatic test_round();
    int cyc;
    setDiag(0);
    A[0][0] = -W'(1);
    setVec(1, 0, 0, 0, 0, 0);
    runEval(cyc);
    testsRun++;
    if (r[0] !== W'(1) || r[1] !== '0 || r[2] !== '0) begin
      testsFailed++;
      $display("[TB] FAIL round_r: got %0d %0d %0d, expected 1 0 0", r[0], r[1], r[2]);
    end
    testsRun++;
    if (norm !== W'(1) || converged !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL round_norm: got norm=%0d conv=%b, expected 1 1", norm, converged);
    end
  endtask

  // Products of max*1.0 push b - acc past both word limits.
  task automatic test_saturation();
    int cyc;
    setAll(8388607);
    setVec(256, 256, 256, -8388608, -8388608, -8388608);
    runEval(cyc);
    for (int k = 0; k < SIZE; k++) begin
      testsRun++;
      if (r[k] !== W'(-8388608)) begin
        testsFailed++;
        $display("[TB] FAIL satneg_r[%0d]: got %0d, expected -8388608", k, r[k]);
      end
    end
    testsRun++;
    if (norm !== W'(8388607) || converged !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL satneg_norm: got norm=%0d conv=%b, expected 8388607 0",
               norm, converged);
    end
    setAll(-8388607);
    setVec(256, 256, 256, 8388607, 8388607, 8388607);
    runEval(cyc);
    testsRun++;
    if (r[0] !== W'(8388607) || r[2] !== W'(8388607) || norm !== W'(8388607)) begin
      testsFailed++;
      $display("[TB] FAIL satpos: got r0=%0d r2=%0d norm=%0d, expected 8388607",
               r[0], r[2], norm);
    end
  endtask

  // Max-by-max product: 2^38-2^16 truncated to 24 bits is -65536 per term,
  // so acc=-196608 and r = -8388608 + 196608 = -8192000 (no saturation).
  task automatic test_wrap();
    int cyc;
    setAll(8388607);
    setVec(8388607, 8388607, 8388607, -8388608, -8388608, -8388608);
    runEval(cyc);
    testsRun++;
    if (r[1] !== W'(-8192000) || norm !== W'(8192000) || converged !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wrap: got r1=%0d norm=%0d conv=%b, expected -8192000 8192000 0",
               r[1], norm, converged);
    end
  endtask

  task automatic test_tolerance();
    int cyc;
    setDiag(256);
    setVec(0, 0, 0, 16, 0, -16);
    runEval(cyc);
    testsRun++;
    if (r[2] !== -W'(16) || norm !== W'(16) || converged !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL tol_at: got r2=%0d norm=%0d conv=%b, expected -16 16 1",
               r[2], norm, converged);
    end
    setVec(0, 0, 0, 0, 17, 0);
    runEval(cyc);
    testsRun++;
    if (norm !== W'(17) || converged !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL tol_over: got norm=%0d conv=%b, expected 17 0", norm, converged);
    end
  endtask

  // Starts at cycles 5 and 12 are ignored; the one at 13 is accepted.
  task automatic test_back_to_back();
    int cyc;
    setDiag(512);
    setVec(256, 256, 256, 768, 768, 768);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 12 || c == 13);
      @(posedge clk);
      #1;
      if (c == 5 || c == 11) begin
        testsRun++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL hs_cycle%0d: got busy=%b ready=%b, expected 1 0", c, busy, ready);
        end
      end
      if (c == 12) begin
        testsRun++;
        if (busy !== 1'b0 || ready !== 1'b1 || norm !== W'(256)) begin
          testsFailed++;
          $display("[TB] FAIL hs_cycle12: got busy=%b ready=%b norm=%0d, expected 0 1 256",
                   busy, ready, norm);
        end
      end
      if (c == 13) begin
        testsRun++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL hs_cycle13: got busy=%b ready=%b, expected 1 0", busy, ready);
        end
      end
    end
    start = 1'b0;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    testsRun++;
    if (cyc !== 12 || r[1] !== W'(256)) begin
      testsFailed++;
      $display("[TB] FAIL hs_second: got latency=%0d r1=%0d, expected 12 256", cyc, r[1]);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    setDiag(512);
    setVec(256, 256, 256, 768, 768, 768);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    I_RSTn = 1'b0;
    #1;
    testsRun++;
    if (busy !== 1'b0 || ready !== 1'b0 || converged !== 1'b0 || norm !== '0) begin
      testsFailed++;
      $display("[TB] FAIL arst_flags: got busy=%b ready=%b conv=%b norm=%0d, expected all 0",
               busy, ready, converged, norm);
    end
    testsRun++;
    if (r[0] !== '0 || r[1] !== '0 || r[2] !== '0) begin
      testsFailed++;
      $display("[TB] FAIL arst_r: got %0d %0d %0d, expected 0 0 0", r[0], r[1], r[2]);
    end
    @(negedge clk);
    I_RSTn = 1'b1;
    setDiag(256);
    setVec(256, 512, -256, 256, 512, -256);
    runEval(cyc);
    testsRun++;
    if (cyc !== 12 || norm !== '0 || converged !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL arst_rerun: got latency=%0d norm=%0d conv=%b, expected 12 0 1",
               cyc, norm, converged);
    end
  endtask

  initial begin
    setDiag(0);
    setVec(0, 0, 0, 0, 0, 0);
    test_reset();
    test_identity();
    test_offset();
    test_sign_shift();
    test_round();
    test_saturation();
    test_wrap();
    test_tolerance();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
